// File: rtl/acondicionador_boton_nivel_pkg.sv
// Shared constants for the level-up button conditioner:
// default timing, button polarity and classifier state encodings.
package acondicionador_boton_nivel_pkg;

  localparam int CLK_HZ = 50_000_000;

  localparam int DEBOUNCE_DEF = CLK_HZ / 100;
  localparam int HOLD_DEF     = CLK_HZ * 5;

  localparam bit ACTIVE_LOW_DEF = 1'b1;

  localparam logic [1:0] SUELTO     = 2'd0;
  localparam logic [1:0] PRESIONADO = 2'd1;
  localparam logic [1:0] LARGO      = 2'd2;

  // Counter width able to hold 0..n-1, never below one bit.
  function automatic int ancho(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/acondicionador_boton_nivel_antirrebote.sv
// Two-FF synchroniser plus debounce for the raw button pin.
// Output deb is the accepted level with pressed = 1.
module acondicionador_boton_nivel_antirrebote
  import acondicionador_boton_nivel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter bit ACTIVE_LOW      = ACTIVE_LOW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boton,
  output logic deb
);

  localparam int CW = ancho(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_FIN =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt_d;

  // Reset parks the synchroniser at the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= boton ^ ACTIVE_LOW;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_d <= '0;
      deb   <= 1'b0;
    end else if (s2 == deb) begin
      cnt_d <= '0;
    end else if (cnt_d == CNT_FIN) begin
      deb   <= s2;
      cnt_d <= '0;
    end else begin
      cnt_d <= cnt_d + 1'b1;
    end
  end

endmodule

// File: rtl/acondicionador_boton_nivel.sv
// Level-up button conditioner: debounced level plus short/long
// press classification feeding the primitive-mode level FSM.
module acondicionador_boton_nivel
  import acondicionador_boton_nivel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int HOLD_CYCLES     = HOLD_DEF,
  parameter bit ACTIVE_LOW      = ACTIVE_LOW_DEF
) (
  input  logic clk,
  input  logic B_reset,
  input  logic Boton_in,
  output logic Entrada_Sube_Nivel,
  output logic Pulso_Corto,
  output logic Boton_Limpio
);

  localparam int HW = ancho(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_FIN =
    HW'(HOLD_CYCLES - 1);

  logic          deb;
  logic [1:0]    estado;
  logic [HW-1:0] cnt_h;

  acondicionador_boton_nivel_antirrebote #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) antirrebote (
    .clk   (clk),
    .rst_n (B_reset),
    .boton (Boton_in),
    .deb   (deb)
  );

  assign Boton_Limpio = deb;

  // Release wins over the terminal hold count in PRESIONADO.
  always_ff @(posedge clk or negedge B_reset) begin
    if (!B_reset) begin
      estado             <= SUELTO;
      cnt_h              <= '0;
      Entrada_Sube_Nivel <= 1'b0;
      Pulso_Corto        <= 1'b0;
    end else begin
      Entrada_Sube_Nivel <= 1'b0;
      Pulso_Corto        <= 1'b0;
      unique case (estado)
        SUELTO: begin
          if (deb) begin
            estado <= PRESIONADO;
            cnt_h  <= '0;
          end
        end
        PRESIONADO: begin
          if (!deb) begin
            estado      <= SUELTO;
            Pulso_Corto <= 1'b1;
          end else if (cnt_h == HOLD_FIN) begin
            estado             <= LARGO;
            Entrada_Sube_Nivel <= 1'b1;
          end else begin
            cnt_h <= cnt_h + 1'b1;
          end
        end
        LARGO: begin
          if (!deb) estado <= SUELTO;
        end
        default: estado <= SUELTO;
      endcase
    end
  end

endmodule
